fir_mac_serial: RTL and testbench

FIR_MAC_SERIAL -- requirements
Module: fir_mac_serial

---
 rtl/fir_mac_serial.sv | 178 +++++++++++++++++
 tb/tb_fir_mac_serial.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_serial.sv
`default_nettype none
// =====================================================================
// Module   : fir_mac_serial
// Brief    : Time-multiplexed direct-form FIR filter. A single shared
//            multiplier walks the taps one per cycle. The result is held
//            behind a valid/ready handshake until it is consumed.
// Options  : FIR_SAT_EN - when defined, y saturates to the signed YW
//            range. When undefined, y takes the low YW accumulator bits
//            and overflow wraps.
// Revision : 1.0 - initial release
// =====================================================================
module fir_mac_serial #(
    parameter int DW   = 10,
    parameter int CW   = 10,
    parameter int TAPS = 8,
    parameter int YW   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [CW-1:0]            coef_wdata,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            x,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [YW-1:0]            y
);

    localparam int ADDR_W = $clog2(TAPS);
    localparam int PW     = DW + CW;
    localparam int AW     = DW + CW + $clog2(TAPS);

    localparam logic [ADDR_W-1:0] LAST_K   = ADDR_W'(TAPS - 1);
    localparam logic [ADDR_W:0]   TAPS_EXT = (ADDR_W + 1)'(TAPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [DW-1:0] xd   [TAPS];
    logic signed [CW-1:0] coef [TAPS];
    logic signed [AW-1:0] acc;
    logic [ADDR_W-1:0]    k;

    logic                 accept;
    logic                 last_tap;
    logic                 addr_ok;
    logic signed [DW-1:0] xk;
    logic signed [CW-1:0] hk;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] acc_nxt;
    logic [YW-1:0]        y_nxt;

    // Handshake qualifiers. Reset gates in_ready so nothing is offered
    // while the block is being cleared.
    assign in_ready  = rst_n & en & (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign last_tap  = (k == LAST_K);
    assign addr_ok   = ({1'b0, coef_addr} < TAPS_EXT);

    // Single shared multiplier. Both operands are sign-extended to the
    // product width so the truncated product is exact.
    assign xk      = xd[k];
    assign hk      = coef[k];
    assign prod    = PW'(xk) * PW'(hk);
    assign acc_nxt = acc + AW'(prod);

    generate
        if (YW < AW) begin : g_narrow
`ifdef FIR_SAT_EN
            localparam logic [YW-1:0] Y_MAX = {1'b0, {(YW-1){1'b1}}};
            localparam logic [YW-1:0] Y_MIN = {1'b1, {(YW-1){1'b0}}};
            logic [AW-YW:0] top_bits;
            assign top_bits = acc_nxt[AW-1:YW-1];
            // Clamp when the bits above the output sign disagree with it.
            always_comb begin
                y_nxt = acc_nxt[YW-1:0];
                if (!((&top_bits) || (~|top_bits))) begin
                    y_nxt = acc_nxt[AW-1] ? Y_MIN : Y_MAX;
                end
            end
`else
            assign y_nxt = acc_nxt[YW-1:0];
`endif
        end else begin : g_wide
            assign y_nxt = YW'(acc_nxt);
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Nothing advances while en is low.
    always_comb begin
        state_nxt = state;
        if (en) begin
            case (state)
                IDLE:    if (accept)    state_nxt = MAC;
                MAC:     if (last_tap)  state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = IDLE;
                default:                state_nxt = IDLE;
            endcase
        end
    end

    // Coefficient bank. It is writable only while idle, so a running
    // computation always sees a stable set of taps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                coef[i] <= '0;
            end
        end else if (en && (state == IDLE) && coef_we && addr_ok) begin
            coef[coef_addr] <= coef_wdata;
        end
    end

    // Sample delay line. It shifts once per accepted sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                xd[i] <= '0;
            end
        end else if (accept) begin
            xd[0] <= x;
            for (int i = 1; i < TAPS; i++) begin
                xd[i] <= xd[i-1];
            end
        end
    end

    // Accumulator, tap counter and output register. On the last tap the
    // final sum goes straight to y.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            k   <= '0;
            y   <= '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc <= '0;
                        k   <= '0;
                    end
                end
                MAC: begin
                    acc <= acc_nxt;
                    if (last_tap) begin
                        k <= '0;
                        y <= y_nxt;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_serial.sv
`default_nettype none
// =====================================================================
// Module   : tb_fir_mac_serial
// Brief    : Self-checking bench for fir_mac_serial. It combines table
//            vectors, hand-written corner sequences and random samples,
//            all scored against an arithmetic FIR model.
// Revision : 1.0 - initial release
// =====================================================================
module tb_fir_mac_serial;

    localparam int DW     = 10;
    localparam int CW     = 10;
    localparam int TAPS   = 8;
    localparam int YW     = 16;
    localparam int ADDR_W = $clog2(TAPS);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              coef_we;
    logic [ADDR_W-1:0] coef_addr;
    logic [CW-1:0]     coef_wdata;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     x;
    logic              out_valid;
    logic              out_ready;
    logic [YW-1:0]     y;

    fir_mac_serial #(.DW(DW), .CW(CW), .TAPS(TAPS), .YW(YW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     xv;
        int     delay;
        longint ey;
    } vec_t;

    vec_t   tbl [8];
    int     total = 0;
    int     bad   = 0;
    longint xm [TAPS];
    longint hm [TAPS];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic longint ys();
        return longint'($signed(y));
    endfunction

    // Reduce a full-precision sum to the YW-bit output.
    function automatic longint fit(input longint s);
        longint lim = longint'(1) <<< (YW - 1);
`ifdef FIR_SAT_EN
        if (s > lim - 1) return lim - 1;
        if (s < -lim) return -lim;
        return s;
`else
        longint r = s % (2 * lim);
        if (r < 0) r += 2 * lim;
        if (r >= lim) r -= 2 * lim;
        return r;
`endif
    endfunction

    function automatic longint model_y();
        longint s = 0;
        for (int i = 0; i < TAPS; i++) s += xm[i] * hm[i];
        return fit(s);
    endfunction

    function automatic int rnd_signed(input int w);
        return int'($urandom_range((1 << w) - 1)) - (1 << (w - 1));
    endfunction

    task automatic do_reset;
        rst_n = 1'b0;
        en = 1'b1;
        in_valid = 1'b0;
        coef_we = 1'b0;
        out_ready = 1'b1;
        tick;
        tick;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_y", ys(), 0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);
        for (int i = 0; i < TAPS; i++) begin
            xm[i] = 0;
            hm[i] = 0;
        end
    endtask

    task automatic write_coef(input int a, input int v);
        coef_we = 1'b1;
        coef_addr = ADDR_W'(a);
        coef_wdata = CW'(v);
        tick;
        coef_we = 1'b0;
        if (a < TAPS) hm[a] = v;
    endtask

    // Push one sample through, optionally freezing en mid-MAC, strobing
    // coef_we mid-MAC, writing a coefficient in the accept cycle, and
    // holding off out_ready for 'delay' DONE cycles.
    task automatic run_sample(input int xv, input int delay, input int fz_len,
                              input bit mac_we, input bit sw, input int sw_addr,
                              input int sw_data, output longint ygot);
        int     cyc;
        longint ye;
        longint y0;
        if (sw) hm[sw_addr] = sw_data;
        for (int i = TAPS - 1; i > 0; i--) xm[i] = xm[i-1];
        xm[0] = xv;
        ye = model_y();

        x = DW'(xv);
        in_valid = 1'b1;
        coef_we = sw;
        coef_addr = ADDR_W'(sw_addr);
        coef_wdata = CW'(sw_data);
        out_ready = (delay == 0);
        #1;
        check("in_ready_idle", in_ready, 1);
        tick;
        in_valid = 1'b0;
        coef_we = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < TAPS + fz_len + 20) begin
            if (mac_we && cyc == 2) begin
                coef_we = 1'b1;
                coef_addr = '0;
                coef_wdata = CW'(rnd_signed(CW));
            end else begin
                coef_we = 1'b0;
            end
            if (fz_len > 0 && cyc == 3) en = 1'b0;
            if (fz_len > 0 && cyc == 3 + fz_len) en = 1'b1;
            tick;
            cyc++;
        end
        en = 1'b1;
        coef_we = 1'b0;
        check("latency", cyc, TAPS + 1 + fz_len);
        check("y", ys(), ye);
        check("busy_in_ready", in_ready, 0);
        y0 = ys();
        for (int i = 1; i < delay; i++) begin
            tick;
            check("hold_valid", out_valid, 1);
            check("hold_y", ys(), y0);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick;
        check("post_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        ygot = y0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        longint yg;
        int     cyc;
        int     seen;
        rst_n = 1'b0;
        en = 1'b1;
        coef_we = 1'b0;
        coef_addr = '0;
        coef_wdata = '0;
        in_valid = 1'b0;
        x = '0;
        out_ready = 1'b1;

        // Impulse response: h = 1..8 reproduced one tap per sample.
        do_reset;
        for (int i = 0; i < TAPS; i++) write_coef(i, i + 1);
        for (int i = 0; i < 8; i++) begin
            tbl[i].xv = (i == 0) ? 1 : 0;
            tbl[i].delay = (i == 2) ? 3 : 0;
            tbl[i].ey = i + 1;
        end
        for (int i = 0; i < 8; i++) begin
            run_sample(tbl[i].xv, tbl[i].delay, 0, 1'b0, 1'b0, 0, 0, yg);
            check("impulse_tbl", yg, tbl[i].ey);
        end

        // Step response with unit taps.
        do_reset;
        for (int i = 0; i < TAPS; i++) write_coef(i, 1);
        for (int i = 0; i < 8; i++) begin
            tbl[i].xv = 5;
            tbl[i].delay = i % 2;
            tbl[i].ey = 5 * (i + 1);
        end
        for (int i = 0; i < 8; i++) begin
            run_sample(tbl[i].xv, tbl[i].delay, 0, 1'b0, 1'b0, 0, 0, yg);
            check("step_tbl", yg, tbl[i].ey);
        end

        // Freeze for 5 cycles mid-MAC plus an ignored coefficient strobe.
        run_sample(3, 0, 5, 1'b1, 1'b0, 0, 0, yg);
        check("freeze_y", yg, 38);

        // Overflow with maximal positive operands.
        do_reset;
        for (int i = 0; i < TAPS; i++) write_coef(i, 511);
        for (int i = 0; i < 8; i++) run_sample(511, 0, 0, 1'b0, 1'b0, 0, 0, yg);
`ifdef FIR_SAT_EN
        check("overflow_final", yg, 32767);
`else
        check("overflow_final", yg, -8184);
`endif

        // Reset asserted on the third MAC cycle aborts the computation.
        x = DW'(9);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready_low", in_ready, 0);
        tick;
        check("midrst_out_valid", out_valid, 0);
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready_high", in_ready, 1);
        for (int i = 0; i < TAPS; i++) begin
            xm[i] = 0;
            hm[i] = 0;
        end
        seen = 0;
        cyc = 0;
        while (cyc < TAPS + 4) begin
            if (out_valid) seen++;
            tick;
            cyc++;
        end
        check("midrst_no_result", seen, 0);
        write_coef(0, 1);
        run_sample(7, 0, 0, 1'b0, 1'b0, 0, 0, yg);
        check("midrst_y7", yg, 7);

        // Random coefficients, samples, backpressure and same-cycle writes.
        do_reset;
        for (int i = 0; i < TAPS; i++) write_coef(i, rnd_signed(CW));
        for (int n = 0; n < 24; n++) begin
            run_sample(rnd_signed(DW), int'($urandom_range(2)), 0, 1'b0,
                       ($urandom_range(3) == 0), int'($urandom_range(TAPS - 1)),
                       rnd_signed(CW), yg);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
